// File: rtl/apb_timer_mc.sv
// apb_timer_mc: NUM_CH-channel APB3 up/down timer with per-channel prescaler, reload and one-shot.
// Optional feature macro TIMER_IRQ_EN: enables TCR.IE and the registered irq output.
module apb_timer_mc #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] ovf,
    output logic [NUM_CH-1:0] udf,
    output logic              irq
);

    localparam logic [3:0]           OFF_TDR  = 4'h0;
    localparam logic [3:0]           OFF_TCR  = 4'h4;
    localparam logic [3:0]           OFF_TSR  = 4'h8;
    localparam logic [3:0]           OFF_TCNT = 4'hC;
    localparam logic [3:0]           NUM_CH_L = 4'(NUM_CH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef TIMER_IRQ_EN
    localparam logic [7:0]           TCR_WMASK = 8'hFF;
`else
    localparam logic [7:0]           TCR_WMASK = 8'hBF;
`endif

    logic [CNT_WIDTH-1:0] tdr_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] tdr_d  [NUM_CH];
    logic [7:0]           tcr_q  [NUM_CH];
    logic [7:0]           tcr_d  [NUM_CH];
    logic [1:0]           tsr_q  [NUM_CH];
    logic [1:0]           tsr_d  [NUM_CH];
    logic [CNT_WIDTH-1:0] tcnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0] tcnt_d [NUM_CH];
    logic [7:0]           psc_q  [NUM_CH];
    logic [7:0]           psc_d  [NUM_CH];
    logic [7:0]           psc_lim_s [NUM_CH];
    logic                 irq_q;
    logic                 irq_d;

    logic [2:0]           ch_s;
    logic [3:0]           off_s;
    logic                 access_s;
    logic                 ch_ok_s;
    logic                 off_ok_s;
    logic                 wr_ok_s;
    logic                 rd_ok_s;
    logic [NUM_CH-1:0]    sel_s;
    logic [NUM_CH-1:0]    wr_tdr_s;
    logic [NUM_CH-1:0]    wr_tcr_s;
    logic [NUM_CH-1:0]    wr_tsr_s;
    logic [NUM_CH-1:0]    tick_s;
    logic [NUM_CH-1:0]    ovf_set_s;
    logic [NUM_CH-1:0]    udf_set_s;
    logic [31:0]          ch_rd_s;
    logic [31:0]          rd_mux_s;
    logic                 unused_s;

    assign unused_s = ^{paddr[7], pwdata};

    // Address decode: channel range, legal offsets, TCNT is read-only.
    always_comb begin
        ch_s     = paddr[6:4];
        off_s    = paddr[3:0];
        access_s = psel & penable;
        ch_ok_s  = ({1'b0, ch_s} < NUM_CH_L);
        case (off_s)
            OFF_TDR, OFF_TCR, OFF_TSR: off_ok_s = 1'b1;
            OFF_TCNT:                  off_ok_s = ~pwrite;
            default:                   off_ok_s = 1'b0;
        endcase
        wr_ok_s = access_s & pwrite & ch_ok_s & off_ok_s;
        rd_ok_s = access_s & ~pwrite & ch_ok_s & off_ok_s;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_s[i] = (ch_s == 3'(i));
        end
    end

    // Read mux; zero outside a legal read access.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        ch_rd_s  = 32'h0000_0000;
        for (int i = 0; i < NUM_CH; i++) begin
            case (off_s)
                OFF_TDR:  ch_rd_s = 32'(tdr_q[i]);
                OFF_TCR:  ch_rd_s = 32'(tcr_q[i]);
                OFF_TSR:  ch_rd_s = 32'(tsr_q[i]);
                OFF_TCNT: ch_rd_s = 32'(tcnt_q[i]);
                default:  ch_rd_s = 32'h0000_0000;
            endcase
            rd_mux_s = rd_mux_s | (sel_s[i] ? ch_rd_s : 32'h0000_0000);
        end
        prdata  = rd_ok_s ? rd_mux_s : 32'h0000_0000;
        pslverr = access_s & ~(ch_ok_s & off_ok_s);
    end

    // Per-channel next state; a TCR write restarts the prescaler and suppresses that cycle's tick.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_tdr_s[i]  = wr_ok_s & sel_s[i] & (off_s == OFF_TDR);
            wr_tcr_s[i]  = wr_ok_s & sel_s[i] & (off_s == OFF_TCR);
            wr_tsr_s[i]  = wr_ok_s & sel_s[i] & (off_s == OFF_TSR);
            psc_lim_s[i] = 8'((9'd2 << tcr_q[i][2:0]) - 9'd1);
            if (wr_tcr_s[i] || !tcr_q[i][4] || tcr_q[i][7]) begin
                psc_d[i]  = 8'h00;
                tick_s[i] = 1'b0;
            end else if (psc_q[i] == psc_lim_s[i]) begin
                psc_d[i]  = 8'h00;
                tick_s[i] = 1'b1;
            end else begin
                psc_d[i]  = psc_q[i] + 8'h01;
                tick_s[i] = 1'b0;
            end

            ovf_set_s[i] = 1'b0;
            udf_set_s[i] = 1'b0;
            if (tcr_q[i][7]) begin
                tcnt_d[i] = tdr_q[i];
            end else if (tick_s[i] && tcr_q[i][5]) begin
                tcnt_d[i]    = tcnt_q[i] - CNT_ONE;
                udf_set_s[i] = (tcnt_q[i] == CNT_ZERO);
            end else if (tick_s[i]) begin
                tcnt_d[i]    = tcnt_q[i] + CNT_ONE;
                ovf_set_s[i] = (tcnt_q[i] == CNT_MAX);
            end else begin
                tcnt_d[i] = tcnt_q[i];
            end

            if (wr_tcr_s[i]) begin
                tcr_d[i] = pwdata[7:0] & TCR_WMASK;
            end else if (tcr_q[i][3] && (ovf_set_s[i] || udf_set_s[i])) begin
                tcr_d[i] = tcr_q[i] & 8'hEF;
            end else begin
                tcr_d[i] = tcr_q[i];
            end

            tdr_d[i] = wr_tdr_s[i] ? pwdata[CNT_WIDTH-1:0] : tdr_q[i];
            tsr_d[i] = (tsr_q[i] & ~(wr_tsr_s[i] ? pwdata[1:0] : 2'b00))
                     | {udf_set_s[i], ovf_set_s[i]};
        end
    end

    // Interrupt request: any channel with IE set and a pending flag.
    always_comb begin
        irq_d = 1'b0;
`ifdef TIMER_IRQ_EN
        for (int i = 0; i < NUM_CH; i++) begin
            irq_d = irq_d | (tcr_q[i][6] & (|tsr_q[i]));
        end
`endif
    end

    // State registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tdr_q[i]  <= CNT_ZERO;
                tcr_q[i]  <= 8'h00;
                tsr_q[i]  <= 2'b00;
                tcnt_q[i] <= CNT_ZERO;
                psc_q[i]  <= 8'h00;
            end
            irq_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                tdr_q[i]  <= tdr_d[i];
                tcr_q[i]  <= tcr_d[i];
                tsr_q[i]  <= tsr_d[i];
                tcnt_q[i] <= tcnt_d[i];
                psc_q[i]  <= psc_d[i];
            end
            irq_q <= irq_d;
        end
    end

    // Status flag outputs.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ovf[i] = tsr_q[i][0];
            udf[i] = tsr_q[i][1];
        end
    end

    assign pready = 1'b1;
    assign irq    = irq_q;

endmodule

// File: tb/tb_apb_timer_mc.sv
// Self-checking bench for apb_timer_mc: directed scenarios with literal expectations plus
// randomized APB traffic, all checked each cycle against a behavioural timer model.
module tb_apb_timer_mc;
    localparam int NCH  = 2;
    localparam int W    = 8;
    localparam int MAXV = 255;
`ifdef TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic           pclk     = 1'b0;
    logic           preset_n = 1'b0;
    logic           psel     = 1'b0;
    logic           penable  = 1'b0;
    logic           pwrite   = 1'b0;
    logic [7:0]     paddr    = 8'h00;
    logic [31:0]    pwdata   = 32'h0;
    logic [31:0]    prdata;
    logic           pready;
    logic           pslverr;
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] udf;
    logic           irq;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    apb_timer_mc #(.NUM_CH(NCH), .CNT_WIDTH(W)) dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .ovf(ovf), .udf(udf), .irq(irq)
    );

    always #5 pclk = ~pclk;

    // Behavioural model: register values as plain integers, prescaler as elapsed cycles.
    int m_tdr[NCH];
    int m_tcr[NCH];
    int m_tsr[NCH];
    int m_cnt[NCH];
    int m_elapsed[NCH];
    bit m_irq;

    function automatic bit fld(input int v, input int b);
        return ((v >> b) & 1) != 0;
    endfunction

    function automatic bit bad_addr(input logic [7:0] a, input logic w);
        int c;
        int o;
        c = int'(a[6:4]);
        o = int'(a[3:0]);
        return (c >= NCH) || !(o == 0 || o == 4 || o == 8 || o == 12) || (w && o == 12);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_tdr[i] = 0; m_tcr[i] = 0; m_tsr[i] = 0; m_cnt[i] = 0; m_elapsed[i] = 0;
        end
        m_irq = 1'b0;
    endtask

    task automatic model_step();
        bit wr;
        bit nirq;
        bit tick;
        int c, o, setf, period, ntcr, clr;
        c    = int'(paddr[6:4]);
        o    = int'(paddr[3:0]);
        wr   = psel && penable && pwrite && !bad_addr(paddr, pwrite);
        nirq = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (IRQ_ON && fld(m_tcr[i], 6) && m_tsr[i] != 0) nirq = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            tick   = 1'b0;
            setf   = 0;
            period = 2 << (m_tcr[i] & 7);
            if ((wr && c == i && o == 4) || !fld(m_tcr[i], 4) || fld(m_tcr[i], 7)) begin
                m_elapsed[i] = 0;
            end else begin
                m_elapsed[i] = m_elapsed[i] + 1;
                if (m_elapsed[i] == period) begin
                    tick = 1'b1;
                    m_elapsed[i] = 0;
                end
            end
            if (fld(m_tcr[i], 7)) m_cnt[i] = m_tdr[i];
            else if (tick && !fld(m_tcr[i], 5)) begin
                if (m_cnt[i] == MAXV) begin m_cnt[i] = 0; setf = 1; end
                else m_cnt[i] = m_cnt[i] + 1;
            end else if (tick) begin
                if (m_cnt[i] == 0) begin m_cnt[i] = MAXV; setf = 2; end
                else m_cnt[i] = m_cnt[i] - 1;
            end
            ntcr = m_tcr[i];
            if (setf != 0 && fld(m_tcr[i], 3)) ntcr = ntcr & ~32'h10;
            if (wr && c == i && o == 4) ntcr = int'(pwdata[7:0]) & (IRQ_ON ? 32'hFF : 32'hBF);
            if (wr && c == i && o == 0) m_tdr[i] = int'(pwdata[7:0]);
            if (wr && c == i && o == 8) begin
                clr = int'(pwdata[1:0]);
                m_tsr[i] = m_tsr[i] & ~clr;
            end
            m_tsr[i] = m_tsr[i] | setf;
            m_tcr[i] = ntcr;
        end
        m_irq = nirq;
    endtask

    function automatic int exp_rd();
        int c;
        int o;
        c = int'(paddr[6:4]);
        o = int'(paddr[3:0]);
        if (!(psel && penable) || pwrite || bad_addr(paddr, pwrite)) return 0;
        case (o)
            0:       return m_tdr[c];
            4:       return m_tcr[c];
            8:       return m_tsr[c];
            default: return m_cnt[c];
        endcase
    endfunction

    function automatic int exp_flag(input int b);
        int v = 0;
        for (int i = 0; i < NCH; i++) if (fld(m_tsr[i], b)) v = v | (1 << i);
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model advance on each clock edge / async reset.
    initial begin
        model_reset();
        forever begin
            @(posedge pclk or negedge preset_n);
            if (!preset_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge pclk);
            if (chk_on) begin
                check("prdata", prdata, 32'(exp_rd()));
                check("pslverr", 32'(pslverr), 32'(psel && penable && bad_addr(paddr, pwrite)));
                check("pready", 32'(pready), 32'd1);
                check("ovf", 32'(ovf), 32'(exp_flag(0)));
                check("udf", 32'(udf), 32'(exp_flag(1)));
                check("irq", 32'(irq), 32'(m_irq));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        rd  = prdata;
        err = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        e;
        apb(1'b1, a, d, r, e);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        apb(1'b0, a, 32'h0, r, e);
        check(nm, r, exp);
        check({nm, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic err_chk(input string nm, input bit w, input logic [7:0] a);
        logic [31:0] r;
        logic        e;
        apb(w, a, 32'hFFFF_FFFF, r, e);
        check(nm, 32'(e), 32'd1);
        check({nm, "_data"}, r, 32'd0);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] r;
        logic        e;
        int          kind;

        repeat (3) @(posedge pclk);
        #1;
        chk_on   = 1'b1;
        preset_n = 1'b1;
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_tcr0", 8'h04, 32'h0);
        rd_chk("rst_tcnt1", 8'h1C, 32'h0);

        // Free-running /2 up count: stopped by a TCR write on the edge that would wrap.
        wr(8'h04, 32'h10);
        idle(509);
        wr(8'h04, 32'h00);
        rd_chk("t1_tcnt", 8'h0C, 32'hFF);
        rd_chk("t1_tsr", 8'h08, 32'h0);
        check("t1_ovf", 32'(ovf), 32'd0);
        idle(50);
        rd_chk("t1_frozen", 8'h0C, 32'hFF);

        // Reload then count up through overflow; sticky flag, irq and W1C.
        wr(8'h00, 32'hFD);
        wr(8'h04, 32'h80);
        wr(8'h04, 32'h50);
        idle(4);
        rd_chk("t2_tcnt", 8'h0C, 32'h00);
        check("t2_ovf", 32'(ovf), 32'd1);
        check("t2_irq", 32'(irq), 32'(IRQ_ON));
        rd_chk("t2_tsr", 8'h08, 32'h1);
        wr(8'h08, 32'h1);
        rd_chk("t2_tsr_clr", 8'h08, 32'h0);
        check("t2_irq_clr", 32'(irq), 32'd0);
        rd_chk("t2_ch1_tcnt", 8'h1C, 32'h0);
        rd_chk("t2_ch1_tsr", 8'h18, 32'h0);
        wr(8'h04, 32'h00);

        // Down count at /16 through underflow; EN must be set for the channel to count.
        wr(8'h10, 32'h02);
        wr(8'h14, 32'h80);
        wr(8'h14, 32'h33);
        idle(48);
        check("t3_udf", 32'(udf), 32'd2);
        check("t3_irq_masked", 32'(irq), 32'd0);
        rd_chk("t3_tcnt", 8'h1C, 32'hFF);
        wr(8'h14, 32'h00);
        wr(8'h18, 32'h3);

        // One-shot: EN drops on wrap and the counter holds.
        wr(8'h00, 32'hFE);
        wr(8'h04, 32'h80);
        wr(8'h04, 32'h18);
        idle(4);
        rd_chk("t4_tcnt", 8'h0C, 32'h00);
        rd_chk("t4_tcr", 8'h04, 32'h08);
        check("t4_ovf", 32'(ovf), 32'd1);
        idle(50);
        rd_chk("t4_hold", 8'h0C, 32'h00);
        wr(8'h08, 32'h1);

        // Asynchronous reset while counting, then a fresh count.
        wr(8'h04, 32'h10);
        idle(20);
        preset_n = 1'b0;
        idle(100);
        check("t5_ovf", 32'(ovf), 32'd0);
        check("t5_udf", 32'(udf), 32'd0);
        check("t5_irq", 32'(irq), 32'd0);
        rd_chk("t5_tcr", 8'h04, 32'h0);
        rd_chk("t5_tdr", 8'h00, 32'h0);
        preset_n = 1'b1;
        wr(8'h04, 32'h10);
        idle(501);
        rd_chk("t5_tcnt", 8'h0C, 32'hFB);
        wr(8'h04, 32'h00);

        // Error responses leave state untouched; IE write mask.
        err_chk("t6_wr_tcnt", 1'b1, 8'h0C);
        rd_chk("t6_tcnt_kept", 8'h0C, 32'hFD);
        err_chk("t6_rd_ch2", 1'b0, 8'h20);
        err_chk("t6_rd_off", 1'b0, 8'h16);
        err_chk("t6_wr_ch2", 1'b1, 8'h24);
        wr(8'h14, 32'h40);
        rd_chk("t6_ie", 8'h14, IRQ_ON ? 32'h40 : 32'h00);
        wr(8'h10, 32'hFF);
        wr(8'h14, 32'hC0);
        wr(8'h14, 32'h50);
        idle(4);
        check("t6_ovf1", 32'(ovf), 32'd2);
        check("t6_irq", 32'(irq), 32'(IRQ_ON));
        wr(8'h14, 32'h00);
        wr(8'h18, 32'h3);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 2500; n++) begin
            kind = $urandom_range(0, 99);
            a = {1'b0, 3'($urandom_range(0, 2)), 4'($urandom_range(0, 3) * 4)};
            if (kind < 4) a = 8'($urandom_range(0, 255));
            d = $urandom;
            if (a[3:0] == 4'h4) d = {24'h0, d[7:3], 3'($urandom_range(0, 2))};
            if (kind < 1) begin
                preset_n = 1'b0;
                idle($urandom_range(1, 4));
                preset_n = 1'b1;
            end else if (kind < 10) begin
                idle($urandom_range(1, 20));
            end else begin
                apb(kind < 55, a, d, r, e);
            end
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
